// File: rtl/chess_clock_pkg.sv
// Shared widths, limits, state encoding and saturating arithmetic for the chess clock core.
package chess_clock_pkg;

  localparam int TIME_W = 12;
  localparam logic [TIME_W-1:0] TIME_MAX = 12'd4095;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_FLAGGED = 2'd3
  } state_t;

  // Adds an increment to a time value, clamping at TIME_MAX instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] t,
                                                input logic [TIME_W:0]   inc);
    logic [TIME_W+1:0] sum;
    sum = {2'b00, t} + {1'b0, inc};
    if (sum > {2'b00, TIME_MAX}) begin
      return TIME_MAX;
    end else begin
      return sum[TIME_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle tick per second of run time.
module sec_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_r;

  assign tick = en && (cnt_r == CNT_LAST);

  // Cycle counter: clear has priority, otherwise counts only while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= tick ? '0 : cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/chess_clock_core.sv
// Two-player chess clock: per-player countdown, turn switching with increment, sticky flags.
module chess_clock_core
  import chess_clock_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEFAULT_TIME = 300,
  parameter int INC_SEC      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        press_a,
  input  logic        press_b,
  input  logic        load,
  input  logic [11:0] load_sec,
  output logic [11:0] time_a,
  output logic [11:0] time_b,
  output logic [11:0] time_active,
  output logic        turn,
  output logic        running,
  output logic        flag_a,
  output logic        flag_b
);

  localparam logic [TIME_W-1:0] DEF_T = TIME_W'(DEFAULT_TIME);
  localparam logic [TIME_W:0]   INC_CLAMP = (INC_SEC > 4095) ? 13'd4095 : 13'(INC_SEC);

  state_t            state_r;
  logic              tick_s;
  logic              pre_en_s;
  logic              pre_clr_s;
  logic              valid_press_s;
  logic              flag_hit_s;
  logic              load_ok_s;
  logic [TIME_W-1:0] dec_s;
  logic [TIME_W-1:0] run_time_s;

  assign time_active   = turn ? time_b : time_a;
  assign valid_press_s = turn ? press_b : press_a;
  assign flag_hit_s    = tick_s && (time_active == 12'd1);
  assign load_ok_s     = load && (load_sec != 12'd0);
  assign dec_s         = tick_s ? (time_active - 12'd1) : time_active;
  assign run_time_s    = valid_press_s ? sat_add(dec_s, INC_CLAMP) : dec_s;

  // The prescaler keeps its count while paused so a resumed second is not lost.
  assign pre_en_s  = (state_r == ST_RUN);
  assign pre_clr_s = ((state_r == ST_IDLE) && start) ||
                     ((state_r == ST_RUN) && valid_press_s && !flag_hit_s);

  sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en_s),
    .clr   (pre_clr_s),
    .tick  (tick_s)
  );

  // Game FSM with both time registers, turn and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      time_a  <= DEF_T;
      time_b  <= DEF_T;
      turn    <= 1'b0;
      running <= 1'b0;
      flag_a  <= 1'b0;
      flag_b  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_ok_s) begin
            time_a <= load_sec;
            time_b <= load_sec;
          end
          if (start) begin
            state_r <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flag_hit_s) begin
            // Expiry beats a same-cycle press: no increment, no turn change.
            if (turn) begin
              time_b <= 12'd0;
              flag_b <= 1'b1;
            end else begin
              time_a <= 12'd0;
              flag_a <= 1'b1;
            end
            state_r <= ST_FLAGGED;
            running <= 1'b0;
          end else begin
            if (turn) begin
              time_b <= run_time_s;
            end else begin
              time_a <= run_time_s;
            end
            if (valid_press_s) begin
              turn <= ~turn;
            end
            if (pause) begin
              state_r <= ST_PAUSED;
              running <= 1'b0;
            end
          end
        end
        ST_PAUSED: begin
          if (load_ok_s) begin
            time_a  <= load_sec;
            time_b  <= load_sec;
            state_r <= ST_IDLE;
          end else if (start) begin
            state_r <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_FLAGGED: begin
          if (load_ok_s) begin
            time_a  <= load_sec;
            time_b  <= load_sec;
            flag_a  <= 1'b0;
            flag_b  <= 1'b0;
            turn    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
